// File: rtl/patch_dump_pkg.sv
// Shared types and constants for the SysEx patch-dump sequencer.
// The COM address list and the OSC offset table live here as lookup functions.
package patch_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_SEND,
        ST_CHK,
        ST_EOX,
        ST_FIN
    } state_e;

    // Section value doubles as the bit index into the one-hot select vector.
    typedef enum logic [1:0] {
        SEC_COM,
        SEC_OSC,
        SEC_M1,
        SEC_M2
    } section_e;

    localparam logic [7:0] SYSEX_SOF = 8'hF0;
    localparam logic [7:0] SYSEX_EOX = 8'hF7;

    localparam int unsigned OSC_OFS_N = 6;
    localparam int unsigned COM_ADR_N = 17;

    function automatic logic [3:0] osc_offset(input logic [2:0] i);
        case (i)
            3'd0:    return 4'd2;
            3'd1:    return 4'd3;
            3'd2:    return 4'd4;
            3'd3:    return 4'd7;
            3'd4:    return 4'd10;
            3'd5:    return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

    // COM list: address 1, then 16..31.
    function automatic logic [6:0] com_adr(input logic [4:0] i);
        if (i == 5'd0) begin
            return 7'd1;
        end
        return {2'b00, i} + 7'd15;
    endfunction

endpackage

// File: rtl/sysex_patch_dump_addr_gen.sv
// Walks COM, OSC, M1 and M2 parameter items on each advance strobe.
// Outputs the current item's address, one-hot section select and last-item flag.
module dump_addr_gen
    import patch_dump_pkg::*;
#(
    parameter int unsigned V_OSC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       advance,
    output logic [6:0] adr,
    output logic [3:0] sel,
    output logic       last
);

    localparam logic [6:0] M_LAST = 7'(16 * V_OSC - 1);

    section_e   sec_q, sec_d;
    logic [6:0] idx_q, idx_d;
    logic [2:0] ofs_q, ofs_d;
    logic [2:0] osc_q, osc_d;

    always_comb begin
        sec_d = sec_q;
        idx_d = idx_q;
        ofs_d = ofs_q;
        osc_d = osc_q;
        if (init) begin
            sec_d = SEC_COM;
            idx_d = '0;
            ofs_d = '0;
            osc_d = '0;
        end else if (advance) begin
            case (sec_q)
                SEC_COM: begin
                    if (idx_q == 7'(COM_ADR_N - 1)) begin
                        sec_d = SEC_OSC;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
                SEC_OSC: begin
                    if (ofs_q == 3'(OSC_OFS_N - 1)) begin
                        ofs_d = '0;
                        if (osc_q == 3'(V_OSC - 1)) begin
                            sec_d = SEC_M1;
                            osc_d = '0;
                        end else begin
                            osc_d = osc_q + 3'd1;
                        end
                    end else begin
                        ofs_d = ofs_q + 3'd1;
                    end
                end
                SEC_M1: begin
                    if (idx_q == M_LAST) begin
                        sec_d = SEC_M2;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
                default: begin
                    if (idx_q == M_LAST) begin
                        sec_d = SEC_COM;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        case (sec_q)
            SEC_COM: adr = com_adr(idx_q[4:0]);
            SEC_OSC: adr = {osc_q, osc_offset(ofs_q)};
            default: adr = idx_q;
        endcase
        sel  = 4'd1 << sec_q;
        last = (sec_q == SEC_M2) && (idx_q == M_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q <= SEC_COM;
            idx_q <= '0;
            ofs_q <= '0;
            osc_q <= '0;
        end else begin
            sec_q <= sec_d;
            idx_q <= idx_d;
            ofs_q <= ofs_d;
            osc_q <= osc_d;
        end
    end

endmodule

// File: rtl/sysex_patch_dump.sv
// Serialises the patch store into one framed MIDI SysEx dump over a valid/ready byte link.
// All store-side and tx-side outputs are registered.
module sysex_patch_dump
    import patch_dump_pkg::*;
#(
    parameter int unsigned V_OSC  = 4,
    parameter logic [7:0]  MFR_ID = 8'h7D,
    parameter logic [7:0]  DEV_ID = 8'h00
) (
    input  logic       data_clk,
    input  logic       reset_data_N,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [6:0] adr,
    output logic       read,
    output logic       osc_sel,
    output logic       com_sel,
    output logic       m1_sel,
    output logic       m2_sel,
    input  logic [7:0] synth_data_out,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    state_e     state_q, state_d;
    logic [1:0] hdr_q, hdr_d;
    logic [6:0] sum_q, sum_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic [6:0] adr_q, adr_d;
    logic [3:0] sel_q, sel_d;
    logic       read_q, read_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       last_q, last_d;

    logic       gen_init, gen_adv, gen_last;
    logic [6:0] gen_adr;
    logic [3:0] gen_sel;
    logic       xfer, load_req;
    logic [6:0] sum_next;

    assign gen_init = (state_q == ST_IDLE) && start;
    // Generator steps once the current address is latched, so the next item is ready by SEND.
    assign gen_adv  = (state_q == ST_RD_REQ);

    dump_addr_gen #(
        .V_OSC(V_OSC)
    ) u_addr_gen (
        .clk    (data_clk),
        .rst_n  (reset_data_N),
        .init   (gen_init),
        .advance(gen_adv),
        .adr    (gen_adr),
        .sel    (gen_sel),
        .last   (gen_last)
    );

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        sum_d      = sum_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        read_d     = read_q;
        busy_d     = busy_q;
        done_d     = done_q;
        last_d     = last_q;
        load_req   = 1'b0;
        xfer       = tx_valid_q && tx_ready;
        sum_next   = sum_q + tx_data_q[6:0];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_HDR;
                    busy_d     = 1'b1;
                    sum_d      = '0;
                    hdr_d      = '0;
                    tx_data_d  = SYSEX_SOF;
                    tx_valid_d = 1'b1;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    case (hdr_q)
                        2'd0: begin
                            tx_data_d = MFR_ID;
                            hdr_d     = 2'd1;
                        end
                        2'd1: begin
                            tx_data_d = DEV_ID;
                            hdr_d     = 2'd2;
                        end
                        default: load_req = 1'b1;
                    endcase
                end
            end
            ST_RD_REQ: begin
                read_d  = 1'b0;
                last_d  = gen_last;
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                tx_data_d  = synth_data_out & 8'h7F;
                tx_valid_d = 1'b1;
                adr_d      = '0;
                sel_d      = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (xfer) begin
                    sum_d = sum_next;
                    if (last_q) begin
                        tx_data_d = {1'b0, 7'd0 - sum_next};
                        state_d   = ST_CHK;
                    end else begin
                        load_req = 1'b1;
                    end
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    tx_data_d = SYSEX_EOX;
                    state_d   = ST_EOX;
                end
            end
            ST_EOX: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    tx_data_d  = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_FIN;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (load_req) begin
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            adr_d      = gen_adr;
            sel_d      = gen_sel;
            read_d     = 1'b1;
            state_d    = ST_RD_REQ;
        end
    end

    always_ff @(posedge data_clk or negedge reset_data_N) begin
        if (!reset_data_N) begin
            state_q    <= ST_IDLE;
            hdr_q      <= '0;
            sum_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            adr_q      <= '0;
            sel_q      <= '0;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            sum_q      <= sum_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            adr_q      <= adr_d;
            sel_q      <= sel_d;
            read_q     <= read_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            last_q     <= last_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign adr      = adr_q;
    assign read     = read_q;
    assign com_sel  = sel_q[SEC_COM];
    assign osc_sel  = sel_q[SEC_OSC];
    assign m1_sel   = sel_q[SEC_M1];
    assign m2_sel   = sel_q[SEC_M2];
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule
